// File: rtl/fir_sched_pkg.sv
// fir_sched_pkg: shared defaults, tap-index width and FSM state type for the FIR MAC scheduler
package fir_sched_pkg;
   localparam int RATE_DEF = 8;
   localparam int NUM_TAPS_DEF = 191;
   localparam int ADDR_WIDTH_DEF = 8;
   localparam int TAP_W = 9;
   typedef enum logic [1:0] {IDLE, RUN, DUMP} state_t;
endpackage

// File: rtl/fir_mac_scheduler_deci.sv
// fir_deci_ctr: per-channel sample-RAM write pointer and decimation counter with end-of-block strobe
module fir_deci_ctr
   import fir_sched_pkg::*;
#(
   parameter int RATE = RATE_DEF,
   parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  s_valid,
   output logic [ADDR_WIDTH-1:0] wr_addr,
   output logic                  strobe
);
   localparam int CW = RATE > 1 ? $clog2(RATE) : 1;
   logic [CW-1:0] cnt;
   assign strobe = s_valid && cnt == CW'(RATE - 1);
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         wr_addr <= '0;
         cnt <= '0;
      end else if (s_valid) begin
         wr_addr <= wr_addr + 1'b1;
         cnt <= strobe ? '0 : cnt + 1'b1;
      end
endmodule

// File: rtl/fir_mac_scheduler.sv
// fir_mac_scheduler: two-channel decimating FIR MAC sequencer with round-robin tie arbitration.
// Define FIR_SCHED_OVERRUN_EN to build sticky per-channel overrun flags.
module fir_mac_scheduler
   import fir_sched_pkg::*;
#(
   parameter int RATE = RATE_DEF,
   parameter int NUM_TAPS = NUM_TAPS_DEF,
   parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [1:0]            s_valid,
   output logic [ADDR_WIDTH-1:0] wr_addr0,
   output logic [ADDR_WIDTH-1:0] wr_addr1,
   output logic [ADDR_WIDTH-1:0] rd_addr,
   output logic                  rd_ch,
   output logic [TAP_W-1:0]      tap_idx,
   output logic                  mac_clear,
   output logic                  mac_en,
   output logic                  mac_dump,
   output logic                  dump_ch,
   output logic                  busy,
   output logic [1:0]            overrun
);
   localparam logic [TAP_W-1:0] LAST = TAP_W'(NUM_TAPS - 1);
   state_t state, state_nx;
   logic [1:0] strobe, pending, clr;
   logic [ADDR_WIDTH-1:0] wr [2];
   logic [ADDR_WIDTH-1:0] base [2];
   logic [ADDR_WIDTH-1:0] rd_ptr;
   logic [TAP_W-1:0] k;
   logic grant, gnt, gnt_nx, tie_pri;

   for (genvar c = 0; c < 2; c++) begin : g_ch
      fir_deci_ctr #(.RATE(RATE), .ADDR_WIDTH(ADDR_WIDTH)) u_ctr (
         .clk(clk),
         .reset(reset),
         .s_valid(s_valid[c]),
         .wr_addr(wr[c]),
         .strobe(strobe[c])
      );
   end

   assign wr_addr0 = wr[0];
   assign wr_addr1 = wr[1];
   assign busy = state != IDLE;
   assign rd_addr = state == RUN ? rd_ptr : '0;
   assign rd_ch = state == RUN && gnt;
   // tie_pri only moves on contested grants, so a lone request never steals the next tie
   assign grant = state == IDLE && pending != 2'b00;
   assign gnt_nx = pending == 2'b11 ? tie_pri : pending[1];
   assign clr = grant ? (gnt_nx ? 2'b10 : 2'b01) : 2'b00;

   always_comb begin
      state_nx = state;
      if (grant) state_nx = RUN;
      else if (state == RUN && k == LAST) state_nx = DUMP;
      else if (state == DUMP) state_nx = IDLE;
   end

   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         state <= IDLE;
         pending <= '0;
         base <= '{default: '0};
         rd_ptr <= '0;
         k <= '0;
         gnt <= 1'b0;
         tie_pri <= 1'b0;
         mac_en <= 1'b0;
         mac_clear <= 1'b0;
         mac_dump <= 1'b0;
         dump_ch <= 1'b0;
         tap_idx <= '0;
      end else begin
         state <= state_nx;
         pending <= (pending & ~clr) | strobe;
         for (int c = 0; c < 2; c++) if (strobe[c]) base[c] <= wr[c];
         // the pass snapshots its start address so later strobes cannot disturb it
         if (grant) begin
            gnt <= gnt_nx;
            rd_ptr <= base[gnt_nx] - ADDR_WIDTH'(NUM_TAPS - 1);
            k <= '0;
            if (pending == 2'b11) tie_pri <= ~gnt_nx;
         end else if (state == RUN) begin
            rd_ptr <= rd_ptr + 1'b1;
            k <= k + 1'b1;
         end
         mac_en <= state == RUN;
         mac_clear <= state == RUN && k == '0;
         tap_idx <= state == RUN ? k : '0;
         mac_dump <= state == DUMP;
         dump_ch <= state == DUMP && gnt;
      end

`ifdef FIR_SCHED_OVERRUN_EN
   always_ff @(posedge clk or posedge reset)
      if (reset) overrun <= '0;
      else overrun <= overrun | (strobe & pending & ~clr);
`else
   assign overrun = 2'b00;
`endif
endmodule

// File: tb/tb_fir_mac_scheduler.sv
// tb_fir_mac_scheduler: table vectors plus scoreboarded MAC passes for fir_mac_scheduler
module tb_fir_mac_scheduler;
   localparam int NT = 191;
   logic clk = 1'b0, reset = 1'b0;
   logic [1:0] s_valid = 2'b00;
   logic [7:0] wr_addr0, wr_addr1, rd_addr;
   logic [8:0] tap_idx;
   logic rd_ch, mac_clear, mac_en, mac_dump, dump_ch, busy;
   logic [1:0] overrun;

   typedef struct { logic ch; logic [7:0] base; } pass_t;
   typedef struct { logic [1:0] sv; logic [7:0] w0; logic [7:0] w1; logic b; } vec_t;
   pass_t sb[$];
   pass_t cur;
   vec_t tbl [12];
   int n_cmp = 0, n_err = 0, cyc = 0;
   int k_mon = 0, n_dump = 0, t_dump = 0, t_first = 0, t_strobe = 0, t0 = 0, nd = 0;
   logic last_dump = 1'b0, prev_ch = 1'b0;
   logic [7:0] prev_rd = '0, first_rd = '0, exp_rd;
   logic [7:0] m_wr [2];
   int m_cnt [2];
   logic [1:0] hit;
   logic [7:0] hb [2];
   logic [1:0] exp_ovr;

   fir_mac_scheduler dut (
      .clk(clk), .reset(reset), .s_valid(s_valid),
      .wr_addr0(wr_addr0), .wr_addr1(wr_addr1), .rd_addr(rd_addr), .rd_ch(rd_ch),
      .tap_idx(tap_idx), .mac_clear(mac_clear), .mac_en(mac_en), .mac_dump(mac_dump),
      .dump_ch(dump_ch), .busy(busy), .overrun(overrun)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic pulse(input logic [1:0] sv);
      s_valid = sv;
      @(posedge clk);
      #1 s_valid = 2'b00;
      hit = 2'b00;
      for (int c = 0; c < 2; c++) if (sv[c]) begin
         if (m_cnt[c] == 7) begin
            hit[c] = 1'b1;
            hb[c] = m_wr[c];
         end
         m_wr[c] = m_wr[c] + 8'd1;
         m_cnt[c] = (m_cnt[c] + 1) % 8;
      end
      if (hit != 2'b00) t_strobe = cyc - 1;
   endtask

   task automatic bring(input logic [1:0] sv);
      for (int c = 0; c < 2; c++) if (sv[c]) while (m_cnt[c] != 7) pulse(c == 0 ? 2'b01 : 2'b10);
   endtask

   task automatic push(input logic ch, input logic [7:0] base);
      pass_t p;
      p.ch = ch;
      p.base = base;
      sb.push_back(p);
   endtask

   task automatic wait_dumps(input int target);
      int n = 0;
      while (n_dump < target && n < 2000) begin
         @(posedge clk);
         n++;
      end
      #1;
      chk("dump_timeout", 32'(n_dump >= target), 1);
   endtask

   task automatic chk_zero(input string name);
      chk({name, "_addr"}, {rd_addr, wr_addr0, wr_addr1}, 0);
      chk({name, "_ctl"}, {tap_idx, rd_ch, mac_clear, mac_en, mac_dump, dump_ch, busy, overrun}, 0);
   endtask

   task automatic model_reset();
      m_wr[0] = '0; m_wr[1] = '0;
      m_cnt[0] = 0; m_cnt[1] = 0;
      sb.delete();
   endtask

   initial forever begin
      @(negedge clk);
      if (reset) k_mon = 0;
      else begin
         if (mac_clear) begin
            if (sb.size() == 0) chk("unexpected_pass", 1, 0);
            else begin
               cur = sb.pop_front();
               first_rd = prev_rd;
               t_first = cyc - 1;
            end
            chk("clear_tap0", 32'(tap_idx), 0);
            k_mon = 0;
         end
         if (mac_en) begin
            exp_rd = cur.base - 8'(NT - 1) + 8'(k_mon);
            chk("tap_idx", 32'(tap_idx), k_mon);
            chk("rd_addr", 32'(prev_rd), 32'(exp_rd));
            chk("rd_ch", 32'(prev_ch), 32'(cur.ch));
            k_mon++;
         end
         if (mac_dump) begin
            chk("dump_ch", 32'(dump_ch), 32'(cur.ch));
            chk("dump_taps", k_mon, NT);
            n_dump++;
            t_dump = cyc;
            last_dump = dump_ch;
         end
         prev_rd = rd_addr;
         prev_ch = rd_ch;
      end
   end

   initial begin
`ifdef FIR_SCHED_OVERRUN_EN
      exp_ovr = 2'b10;
`else
      exp_ovr = 2'b00;
`endif
      tbl = '{
         '{2'b01, 8'd1, 8'd0, 1'b0}, '{2'b10, 8'd1, 8'd1, 1'b0}, '{2'b11, 8'd2, 8'd2, 1'b0},
         '{2'b00, 8'd2, 8'd2, 1'b0}, '{2'b01, 8'd3, 8'd2, 1'b0}, '{2'b01, 8'd4, 8'd2, 1'b0},
         '{2'b01, 8'd5, 8'd2, 1'b0}, '{2'b01, 8'd6, 8'd2, 1'b0}, '{2'b01, 8'd7, 8'd2, 1'b0},
         '{2'b01, 8'd8, 8'd2, 1'b0}, '{2'b10, 8'd8, 8'd3, 1'b1}, '{2'b10, 8'd8, 8'd4, 1'b1}};
      model_reset();
      #2 reset = 1'b1;
      #1 chk_zero("reset");
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;

      for (int i = 0; i < 12; i++) begin
         pulse(tbl[i].sv);
         if (hit[0]) push(1'b0, hb[0]);
         chk($sformatf("vec%0d_wr0", i), 32'(wr_addr0), 32'(tbl[i].w0));
         chk($sformatf("vec%0d_wr1", i), 32'(wr_addr1), 32'(tbl[i].w1));
         chk($sformatf("vec%0d_busy", i), 32'(busy), 32'(tbl[i].b));
      end
      wait_dumps(1);
      chk("first_rd", 32'(first_rd), 73);
      chk("rd_latency", t_first - t_strobe, 2);
      chk("dump_latency", t_dump - t_strobe, 194);
      chk("ovr_none", 32'(overrun), 0);

      bring(2'b11);
      pulse(2'b11);
      push(1'b0, hb[0]);
      push(1'b1, hb[1]);
      wait_dumps(n_dump + 1);
      t0 = t_dump;
      chk("tie_first", 32'(last_dump), 0);
      wait_dumps(n_dump + 1);
      chk("dump_spacing", t_dump - t0, 193);
      bring(2'b11);
      pulse(2'b11);
      push(1'b1, hb[1]);
      push(1'b0, hb[0]);
      wait_dumps(n_dump + 1);
      chk("tie_rr", 32'(last_dump), 1);
      wait_dumps(n_dump + 1);

      bring(2'b01);
      pulse(2'b01);
      push(1'b0, hb[0]);
      for (int i = 0; i < 16; i++) pulse(2'b10);
      push(1'b1, hb[1]);
      chk("ovr_set", 32'(overrun), 32'(exp_ovr));
      wait_dumps(n_dump + 2);
      chk("ovr_sticky", 32'(overrun), 32'(exp_ovr));

      bring(2'b01);
      pulse(2'b01);
      push(1'b0, hb[0]);
      begin
         int n = 0;
         do begin
            @(negedge clk);
            n++;
         end while (!(mac_en && tap_idx == 9'd100) && n < 400);
         chk("reach_k100", 32'(n < 400), 1);
      end
      nd = n_dump;
      #2 reset = 1'b1;
      #1 chk_zero("mid_reset");
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      model_reset();
      repeat (200) @(posedge clk);
      #1 chk("no_dump_after_abort", n_dump, nd);
      chk("ovr_cleared", 32'(overrun), 0);
      for (int i = 0; i < 8; i++) pulse(2'b01);
      push(1'b0, hb[0]);
      wait_dumps(nd + 1);
      chk("fresh_first_rd", 32'(first_rd), 73);
      chk("fresh_latency", t_dump - t_strobe, 194);
      chk("sb_empty", sb.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
